// File: rtl/ram_port_ctrl.sv
// Valid/ready bus front end for one dpram port with a 2-entry in-order response buffer.
// Define RAM_PORT_CTRL_RANGE_CHK_EN to flag out-of-window requests instead of aliasing them.
module ram_port_ctrl #(
  parameter int unsigned RAM_DEPTH = 2048,
  parameter int unsigned RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [3:0]        req_wem,
  input  logic [31:0]       req_wdata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  logic [31:0] off;
  logic        range_err;
  logic        accept;
  logic        unused_off;

  assign off        = req_addr - BASE_ADDR;
  assign unused_off = ^{off[31:RAM_AW+2], off[1:0]};

`ifdef RAM_PORT_CTRL_RANGE_CHK_EN
  // One bit wider so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] WinEnd = {1'b0, BASE_ADDR} + 33'(RAM_DEPTH) * 33'd4;
  assign range_err = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= WinEnd);
`else
  assign range_err = 1'b0;
`endif

  // Response path state
  logic        inflight_q, inflight_d;
  logic        if_read_q, if_read_d;
  logic        if_err_q, if_err_d;
  logic [1:0]  occ_q, occ_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] buf_rdata_q [2];
  logic [31:0] buf_rdata_d [2];
  logic [1:0]  buf_err_q, buf_err_d;

  logic [1:0]  outstanding;
  logic [31:0] if_rdata;
  logic        buf_empty;
  logic        push;
  logic        pop;

  // Ready only looks at registered occupancy, never at rsp_rdy.
  assign outstanding = occ_q + {1'b0, inflight_q};
  assign req_rdy     = rst_n && (outstanding < 2'd2);
  assign accept      = req_vld && req_rdy;

  assign ram_en   = accept && !range_err;
  assign ram_we   = req_we;
  assign ram_wem  = req_wem;
  assign ram_din  = req_wdata;
  assign ram_addr = off[RAM_AW+1:2];

  assign if_rdata  = if_read_q ? ram_dout : 32'h0;
  assign buf_empty = (occ_q == 2'd0);

  always_comb begin
    rsp_vld   = !buf_empty || inflight_q;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    if (!buf_empty) begin
      rsp_rdata = buf_rdata_q[rd_ptr_q];
      rsp_err   = buf_err_q[rd_ptr_q];
    end else if (inflight_q) begin
      rsp_rdata = if_rdata;
      rsp_err   = if_err_q;
    end
  end

  always_comb begin
    pop         = !buf_empty && rsp_rdy;
    // A bypassed response that is not taken this cycle must be parked.
    push        = inflight_q && !(buf_empty && rsp_rdy);
    inflight_d  = accept;
    if_read_d   = accept && !req_we && !range_err;
    if_err_d    = accept && range_err;
    rd_ptr_d    = pop ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
    buf_rdata_d = buf_rdata_q;
    buf_err_d   = buf_err_q;
    if (push) begin
      buf_rdata_d[wr_ptr_q] = if_rdata;
      buf_err_d[wr_ptr_q]   = if_err_q;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q     <= 1'b0;
      if_read_q      <= 1'b0;
      if_err_q       <= 1'b0;
      occ_q          <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      buf_rdata_q[0] <= 32'h0;
      buf_rdata_q[1] <= 32'h0;
      buf_err_q      <= 2'b00;
    end else begin
      inflight_q     <= inflight_d;
      if_read_q      <= if_read_d;
      if_err_q       <= if_err_d;
      occ_q          <= occ_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      buf_rdata_q[0] <= buf_rdata_d[0];
      buf_rdata_q[1] <= buf_rdata_d[1];
      buf_err_q      <= buf_err_d;
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural dpram and an in-order response scoreboard.
module tb_ram_port_ctrl;

  localparam int unsigned Depth = 2048;
  localparam int unsigned Aw    = 11;
  localparam logic [31:0] Base  = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          req_vld;
  logic          req_rdy;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [3:0]    req_wem;
  logic [31:0]   req_wdata;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          ram_en;
  logic          ram_we;
  logic [3:0]    ram_wem;
  logic [Aw-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem    [Depth];
  logic [31:0] shadow [Depth];

  ram_port_ctrl #(
    .RAM_DEPTH (Depth),
    .BASE_ADDR (Base)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wem   (req_wem),
    .req_wdata (req_wdata),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_wem   (ram_wem),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port behaviour of the dpram: byte-masked write, 1-cycle read, dout held otherwise.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
        end
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_vld) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed rsp_vld=1 with 0 pending, expected rsp_vld=0");
      end
      if (rsp_rdy && sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.chk_lat) check("rsp_latency", 32'(cyc - e.acc), 32'd1);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] wem,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input bit chk_lat,
                      output logic en_seen, output int waited);
    exp_t        e;
    logic [31:0] off;
    req_vld   = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wem   = wem;
    req_wdata = wdata;
    waited    = 0;
    en_seen   = 1'b0;
    @(negedge clk);
    while (!req_rdy && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!req_rdy) begin
      check("req_accept", 32'(req_rdy), 32'd1);
      @(posedge clk);
      #1 req_vld = 1'b0;
      return;
    end
    en_seen   = ram_en;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.acc     = cyc;
    e.chk_lat = chk_lat;
    sb.push_back(e);
    if (we && !exp_err) begin
      off = addr - Base;
      for (int b = 0; b < 4; b++) begin
        if (wem[b]) shadow[off[Aw+1:2]][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    @(posedge clk);
    #1 req_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic        en;
  int          w;
  logic [31:0] word;

  initial begin
    for (int i = 0; i < int'(Depth); i++) begin
      word      = (32'(i) * 32'h0001_0203) ^ 32'hA500_0000;
      mem[i]    = word;
      shadow[i] = word;
    end
    rst_n     = 1'b0;
    req_vld   = 1'b1;
    req_addr  = 32'h40;
    req_we    = 1'b0;
    req_wem   = 4'hF;
    req_wdata = 32'h0;
    rsp_rdy   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    req_vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Write then read-after-write on consecutive cycles
    send(1'b1, 32'h10, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 1'b1, en, w);
    check("wr_en", 32'(en), 32'd1);
    send(1'b0, 32'h10, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 1'b1, en, w);

    // Byte strobes, then an all-zero strobe write that must leave memory unchanged
    send(1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 1'b1, en, w);
    send(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b1, en, w);
    send(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, 1'b1, en, w);
    send(1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, en, w);
    check("wem0_en", 32'(en), 32'd1);
    send(1'b0, 32'h23, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, 1'b1, en, w);
    drain();

    // Response stall: two accepts, then ready must drop
    rsp_rdy = 1'b0;
    send(1'b0, 32'h0, 4'hF, 32'h0, shadow[0], 1'b0, 1'b0, en, w);
    send(1'b0, 32'h4, 4'hF, 32'h0, shadow[1], 1'b0, 1'b0, en, w);
    req_vld  = 1'b1;
    req_addr = 32'h8;
    repeat (3) begin
      @(negedge clk);
      check("stall_req_rdy", 32'(req_rdy), 32'd0);
    end
    @(posedge clk);
    #1 rsp_rdy = 1'b1;
    send(1'b0, 32'h8, 4'hF, 32'h0, shadow[2], 1'b0, 1'b0, en, w);
    check("stall_accept_wait", 32'(w), 32'd1);
    drain();

    // Full throughput: 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 32'(i * 4), 4'hF, 32'h0, shadow[i], 1'b0, 1'b1, en, w);
      check("tput_wait", 32'(w), 32'd0);
    end
    drain();

    // First address past the window
`ifdef RAM_PORT_CTRL_RANGE_CHK_EN
    send(1'b0, Base + 32'(4 * Depth), 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, en, w);
    check("range_en", 32'(en), 32'd0);
`else
    send(1'b0, Base + 32'(4 * Depth), 4'hF, 32'h0, shadow[0], 1'b0, 1'b1, en, w);
    check("alias_en", 32'(en), 32'd1);
`endif
    drain();

    // Reset with two responses buffered
    rsp_rdy = 1'b0;
    send(1'b0, 32'h30, 4'hF, 32'h0, shadow[12], 1'b0, 1'b0, en, w);
    send(1'b0, 32'h34, 4'hF, 32'h0, shadow[13], 1'b0, 1'b0, en, w);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("midrst_req_rdy", 32'(req_rdy), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 32'h10, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 1'b1, en, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
- Bus-side front end for one dpram port (typically port b, the read/write port).
- Converts a valid/ready request/response bus into dpram control signals: en, we, byte-write mask, word address.
- Absorbs the RAM's fixed 1-cycle read latency and response back-pressure with a 2-entry in-order response buffer.
- Sustains one request per cycle when the response side never stalls.

Parameters:
- RAM_DEPTH, 2048, number of 32-bit words in the attached dpram.
- RAM_AW, clogb2(RAM_DEPTH-1), word-address width driven to the RAM; derived, do not override.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be 4-byte aligned.

Ports:
- clk  in  1  clock, shared with the dpram.
- rst_n  in  1  reset; asynchronous, active-low.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; a transfer occurs when req_vld && req_rdy.
- req_addr  in  32  byte address; bits [1:0] are ignored.
- req_we  in  1  1 = write, 0 = read.
- req_wem  in  4  byte write strobes; bit i selects data byte [8i+7:8i].
- req_wdata  in  32  write data.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_rdata  out  32  read data; 0 for write responses.
- rsp_err  out  1  address outside the RAM window.
- ram_en  out  1  to dpram en.
- ram_we  out  1  to dpram we.
- ram_wem  out  4  to dpram wem.
- ram_addr  out  RAM_AW  to dpram addr (word index).
- ram_din  out  32  to dpram din.
- ram_dout  in  32  from dpram dout; valid the cycle after a read issue, then held while en=0.

Behaviour:
- Reset state: req_rdy=0 while rst_n=0. rsp_vld=0, rsp_rdata=0, rsp_err=0, ram_en=0. Buffer empty, inflight=0.
- Reset asserted mid-operation: buffered responses and the in-flight response are discarded. No response is ever issued for them.
- Address mapping: off = req_addr - BASE_ADDR; ram_addr = off[RAM_AW+1:2]. ram_din = req_wdata, ram_wem = req_wem, ram_we = req_we. These paths are combinational.
- Issue: ram_en = req_vld && req_rdy && !range_err. Every accepted request produces exactly one response, in acceptance order.
- State: inflight (1 bit, set the cycle after an accepted request). occ (0..2) entries in the response buffer, with rd/wr pointers.
- Capture: each entry holds {rdata, err, is_read}. For a read, rdata is taken from ram_dout the cycle after issue. For write and err responses, rdata=0.
- Ready rule: req_rdy = rst_n && (occ + inflight < 2). Must not depend combinationally on rsp_rdy.
- Response source:
  - occ > 0: buffer head.
  - occ == 0 && inflight: bypass the in-flight response directly (rdata = ram_dout for reads).
  - rsp_vld = (occ > 0) || inflight.
- Bypass not accepted (inflight && occ==0 && !rsp_rdy): the in-flight response is written into the buffer at end of cycle.
- Buffer head popped while inflight=1: the in-flight response is pushed to the buffer in the same cycle.
- Simultaneous push and pop: occ is unchanged.
- Throughput/latency:
  - rsp_rdy held 1: 1 response per cycle, latency 1 (response in cycle t+1 for an accept in cycle t).
  - Stall: at most 2 outstanding, after which req_rdy=0.
- Write with req_wem=4'b0000: ram_en still asserts, memory is unchanged, a normal write response is returned.
- Read-after-write to the same address in consecutive cycles returns the new data. The RAM write completes at the first edge; the read samples at the next edge.

Optional Feature:
- Macro RAM_PORT_CTRL_RANGE_CHK_EN.
- Defined:
  - range_err = (req_addr < BASE_ADDR) || (req_addr >= BASE_ADDR + 4*RAM_DEPTH).
  - Erroring requests: no RAM access (ram_en=0), response carries rsp_err=1 and rsp_rdata=0, ordering preserved.
- Undefined:
  - range_err is constant 0 and rsp_err is tied 0.
  - Out-of-window addresses alias modulo the RAM size.

Test Plan:
- Reset then write 0x12345678 to 0x10 with wem=4'hF, then read 0x10 with rsp_rdy=1 -> write rsp in cycle t+1 (rdata 0, err 0); read rsp rdata=0x12345678 in cycle t+2.
- Write wem=4'b0101, data 0xAABBCCDD, over 0x11223344 at 0x20, then read -> 0x11BB33DD.
- rsp_rdy=0, continuous reads of 0x0,0x4,0x8 -> req_rdy drops after 2 accepts. Raise rsp_rdy -> responses in order, third request then accepted, no loss or duplication.
- Back-to-back reads of 0x0..0x3C with rsp_rdy=1 -> req_rdy stays 1, 16 responses on 16 consecutive cycles.
- With RAM_PORT_CTRL_RANGE_CHK_EN, read BASE_ADDR+4*RAM_DEPTH -> ram_en=0, rsp_err=1, rdata=0. Without the macro -> reads word 0.
- Assert rst_n=0 with 2 responses buffered -> rsp_vld=0 immediately. After release, no stale response appears.
